// File: rtl/mux_stream_pkg.sv
// Shared types and default widths for the stream multiplexer family.
package mux_stream_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/mux_stream_sel_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt,
    output logic              gnt_valid
);

    assign gnt_valid = |req;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        logic [SEL_W:0] sum;
        gnt = '0;
        sum = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (sum >= (SEL_W + 1)'(NUM_CH)) begin
                sum = sum - (SEL_W + 1)'(NUM_CH);
            end
            if (req[sum[SEL_W-1:0]]) begin
                gnt = sum[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_stream_sel.sv
// Registered N:1 stream mux with valid/ready handshakes, fixed-select or round-robin grant.
module mux_stream_sel
    import mux_stream_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        y,
    output logic [SEL_W-1:0]         y_ch,
    output logic                     y_valid,
    input  logic                     y_ready
);

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [DATA_W-1:0] y_q, y_d;
    logic [SEL_W-1:0]  y_ch_q, y_ch_d;
    logic              y_valid_q, y_valid_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              is_rr;
    logic              load_en;
    logic              sel_in_range;
    logic              fix_valid;
    logic [SEL_W-1:0]  rr_gnt;
    logic              rr_valid;
    logic [SEL_W-1:0]  gnt;
    logic              gnt_valid;
    logic              accept;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*DATA_W +: DATA_W];
            assign in_ready[gi] = !rst && load_en && gnt_valid && (gnt == SEL_W'(gi));
        end
    endgenerate

    assign is_rr   = (mux_mode_e'(mode) == MODE_RR);
    assign load_en = !y_valid_q || y_ready;

    // A select beyond the channel count (non power-of-two NUM_CH) never grants.
    assign sel_in_range = ({1'b0, sel} < (SEL_W + 1)'(NUM_CH));
    assign fix_valid    = sel_in_range ? in_valid[sel] : 1'b0;

    rr_arbiter #(
        .NUM_CH    (NUM_CH)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt       (rr_gnt),
        .gnt_valid (rr_valid)
    );

    assign gnt       = is_rr ? rr_gnt : sel;
    assign gnt_valid = is_rr ? rr_valid : fix_valid;
    assign accept    = |(in_ready & in_valid);

    always_comb begin
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        y_valid_d = y_valid_q;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            y_d       = ch_data[gnt];
            y_ch_d    = gnt;
            y_valid_d = 1'b1;
            if (is_rr) begin
                rr_ptr_d = (gnt == SEL_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
            end
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            y_valid_q <= y_valid_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_stream_sel.sv
// Directed bench for mux_stream_sel: a 4-channel instance plus a 3-channel one for out-of-range select.
module tb_mux_stream_sel;

    logic        clk;
    logic        rst;

    logic [15:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic        mode4;
    logic [1:0]  sel4;
    logic [3:0]  y4;
    logic [1:0]  y_ch4;
    logic        y_valid4;
    logic        y_ready4;

    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [3:0]  y3;
    logic [1:0]  y_ch3;
    logic        y_valid3;
    logic        y_ready3;

    int total = 0;
    int bad   = 0;

    mux_stream_sel #(.NUM_CH(4), .DATA_W(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data4),
        .in_valid (in_valid4),
        .in_ready (in_ready4),
        .mode     (mode4),
        .sel      (sel4),
        .y        (y4),
        .y_ch     (y_ch4),
        .y_valid  (y_valid4),
        .y_ready  (y_ready4)
    );

    mux_stream_sel #(.NUM_CH(3), .DATA_W(4)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data3),
        .in_valid (in_valid3),
        .in_ready (in_ready3),
        .mode     (mode3),
        .sel      (sel3),
        .y        (y3),
        .y_ch     (y_ch3),
        .y_valid  (y_valid3),
        .y_ready  (y_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ey, input logic [1:0] ech, input logic ev);
        chk({tag, ".y"}, 32'(y4), 32'(ey));
        chk({tag, ".y_ch"}, 32'(y_ch4), 32'(ech));
        chk({tag, ".y_valid"}, 32'(y_valid4), 32'(ev));
    endtask

    initial begin
        rst       = 1'b1;
        in_data4  = 16'h4321;
        in_valid4 = 4'b1111;
        mode4     = 1'b1;
        sel4      = 2'd0;
        y_ready4  = 1'b1;
        in_data3  = 12'h987;
        in_valid3 = 3'b000;
        mode3     = 1'b0;
        sel3      = 2'd0;
        y_ready3  = 1'b1;

        // Reset held with every input asserted
        tick();
        tick();
        chk("rst.in_ready", 32'(in_ready4), 32'b0000);
        chk_out("rst", 4'h0, 2'd0, 1'b0);

        // Round-robin over all channels from pointer 0
        rst = 1'b0;
        #1;
        chk("rr.first_ready", 32'(in_ready4), 32'b0001);
        tick(); chk_out("rr0", 4'h1, 2'd0, 1'b1);
        chk("rr0.in_ready", 32'(in_ready4), 32'b0010);
        tick(); chk_out("rr1", 4'h2, 2'd1, 1'b1);
        tick(); chk_out("rr2", 4'h3, 2'd2, 1'b1);
        tick(); chk_out("rr3", 4'h4, 2'd3, 1'b1);
        tick(); chk_out("rr4", 4'h1, 2'd0, 1'b1);
        tick(); chk_out("rr5", 4'h2, 2'd1, 1'b1);

        // Steer pointer to 1, then only channels 0 and 3 request
        in_valid4 = 4'b0001;
        tick(); chk_out("rrp", 4'h1, 2'd0, 1'b1);
        in_valid4 = 4'b1001;
        #1;
        chk("rr9.in_ready", 32'(in_ready4), 32'b1000);
        tick(); chk("rr9a.y_ch", 32'(y_ch4), 32'd3);
        tick(); chk("rr9b.y_ch", 32'(y_ch4), 32'd0);
        tick(); chk("rr9c.y_ch", 32'(y_ch4), 32'd3);
        tick(); chk("rr9d.y_ch", 32'(y_ch4), 32'd0);

        // Backpressure: load 0x5 from ch1 (pointer is 1), then stall
        in_data4[7:4] = 4'h5;
        in_valid4 = 4'b0010;
        tick(); chk_out("bp.load", 4'h5, 2'd1, 1'b1);
        y_ready4  = 1'b0;
        in_valid4 = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.in_ready", 32'(in_ready4), 32'b0000);
            tick();
            chk_out("bp.hold", 4'h5, 2'd1, 1'b1);
        end
        y_ready4 = 1'b1;
        #1;
        chk("bp.release_ready", 32'(in_ready4), 32'b0100);
        tick(); chk_out("bp.next", 4'h3, 2'd2, 1'b1);

        // Fixed select of ch2, back-to-back beats
        mode4     = 1'b0;
        sel4      = 2'd2;
        in_valid4 = 4'b0100;
        in_data4[11:8] = 4'hA;
        #1;
        chk("fix.in_ready", 32'(in_ready4), 32'b0100);
        tick(); chk_out("fix.a", 4'hA, 2'd2, 1'b1);
        in_data4[11:8] = 4'hB;
        tick(); chk_out("fix.b", 4'hB, 2'd2, 1'b1);
        in_valid4 = 4'b0000;
        tick(); chk_out("fix.drain", 4'hB, 2'd2, 1'b0);

        // Fixed accept of ch0 must leave the RR pointer at 3
        sel4      = 2'd0;
        in_valid4 = 4'b0001;
        tick(); chk_out("fix.ch0", 4'h1, 2'd0, 1'b1);
        mode4     = 1'b1;
        in_valid4 = 4'b1111;
        #1;
        chk("rrptr.in_ready", 32'(in_ready4), 32'b1000);
        tick(); chk_out("rrptr.grant", 4'h4, 2'd3, 1'b1);

        // Reset while stalled discards the held beat
        in_valid4 = 4'b0000;
        y_ready4  = 1'b0;
        tick(); chk("stall.y_valid", 32'(y_valid4), 32'd1);
        rst = 1'b1;
        tick();
        chk_out("midrst", 4'h0, 2'd0, 1'b0);
        rst      = 1'b0;
        y_ready4 = 1'b1;
        tick();
        chk("midrst.after", 32'(y_valid4), 32'd0);
        in_valid4 = 4'b1111;
        #1;
        chk("midrst.ptr", 32'(in_ready4), 32'b0001);

        // Three-channel instance: out-of-range select
        in_valid3 = 3'b111;
        #1;
        chk("oor.sel0_ready", 32'(in_ready3), 32'b001);
        tick();
        chk("oor.load.y", 32'(y3), 32'h7);
        chk("oor.load.valid", 32'(y_valid3), 32'd1);
        sel3 = 2'd3;
        #1;
        chk("oor.in_ready", 32'(in_ready3), 32'b000);
        tick();
        chk("oor.drain.valid", 32'(y_valid3), 32'd0);
        chk("oor.drain.y", 32'(y3), 32'h7);
        chk("oor.idle_ready", 32'(in_ready3), 32'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_stream_sel.md
Name: mux_stream_sel

Overview:
- Parametrised, registered N:1 stream multiplexer; the next generation of the team's 4:1 4-bit combinational mux.
- Adds per-channel valid/ready handshakes, a one-stage output register with backpressure, and two selection modes: fixed select and round-robin arbitration.
- Sits between parallel producer channels and a single downstream consumer in the datapath testbench environment.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DATA_W, 4, data width per channel (>=1).
- SEL_W, $clog2(NUM_CH), width of select and channel-ID fields (derived; not overridden).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational.
- mode  input  1  0 = MODE_FIXED, 1 = MODE_RR.
- sel  input  SEL_W  channel select; used only in MODE_FIXED.
- y  output  DATA_W  registered output data.
- y_ch  output  SEL_W  channel ID of the beat held in y.
- y_valid  output  1  output beat valid.
- y_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1 at posedge): y=0, y_ch=0, y_valid=0, rr_ptr=0. in_ready is 0 while rst=1. Any held beat is discarded.
- load_en = !y_valid || y_ready. The output register accepts a new beat on the same edge the current one drains, giving full throughput: 1 beat/cycle with no bubble.
- Grant in MODE_FIXED:
  - gnt_valid = (sel < NUM_CH) && in_valid[sel]; gnt = sel.
  - An out-of-range sel yields no grant and all in_ready=0.
- Grant in MODE_RR:
  - gnt is the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_CH.
  - gnt_valid = |in_valid.
- in_ready[i] = !rst && load_en && gnt_valid && (gnt == i). At most one bit is set.
- Accept: when in_valid[gnt] && in_ready[gnt], the next edge loads y = channel gnt data, y_ch = gnt, y_valid = 1.
- Drain: if y_valid && y_ready and there is no accept, the next edge sets y_valid = 0. y and y_ch hold their last values.
- Stall: if y_valid && !y_ready, then y, y_ch and y_valid hold, and all in_ready = 0.
- rr_ptr updates only on accept in MODE_RR: rr_ptr = (gnt+1) mod NUM_CH, wrapping from NUM_CH-1 to 0. It is not updated in MODE_FIXED.
- Latency: 1 cycle from accept edge to y_valid.
- Changes to mode or sel take effect combinationally for the next accept and never alter a held beat.
- Input channels must hold data stable while valid && !ready. The block does not check this.

Decomposition:
- Package mux_stream_pkg:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_e.
  - Default-width localparams.
- Sub-module rr_arbiter (NUM_CH): inputs req, ptr; outputs gnt index and gnt_valid. Purely combinational rotate-priority search, reusable elsewhere.
- The top level holds the output register, rr_ptr, the handshake logic, and the fixed-mode select path.

Test Plan (NUM_CH=4, DATA_W=4 unless noted):
- Reset:
  - Stimulus: drive rst=1 for 2 cycles with all in_valid=1 and y_ready=1.
  - Required: in_ready=0000, y_valid=0, y=0, y_ch=0.
  - Release rst: first accept in MODE_RR is ch0.
- Fixed mode, full throughput:
  - Stimulus: mode=0, sel=2, in_valid=0100, ch2 data 0xA then 0xB on consecutive accepts, y_ready=1.
  - Required: y=0xA, y_ch=2 one cycle after the first accept; y=0xB on the next cycle; y_valid stays high with no bubble.
- Round-robin wrap:
  - Stimulus: mode=1, all in_valid=1 continuously, y_ready=1.
  - Required: y_ch sequence 0,1,2,3,0,1.
  - With in_valid=1001 from rr_ptr=1, the grant order is 3,0,3,0.
- Backpressure:
  - Stimulus: beat 0x5 held in y, y_ready=0 for 3 cycles.
  - Required: y=0x5 stable, all in_ready=0, rr_ptr unchanged; y_ready=1 drains the beat and accepts the next one on the same edge.
- Out-of-range select (NUM_CH=3, SEL_W=2):
  - Stimulus: mode=0, sel=3, all valid.
  - Required: in_ready=000, y_valid drops after the drain.
- Reset mid-stall:
  - Stimulus: y_valid=1, y_ready=0, then rst=1 for 1 cycle.
  - Required: y_valid=0 and y=0 next cycle; the held beat is never observed with y_ready=1.
